shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, default 4, width of the step-count input cnt.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  command request; sampled only in IDLE.
REQ-005 op  input  1  command type: 0 = rotate left, 1 = shift right with serial-in.
REQ-006 init  input  4  value loaded into the shift register at command start.
REQ-007 cnt  input  CNT_W  number of shift/rotate steps, 0..2^CNT_W-1.
REQ-008 si_pat  input  4  serial-in pattern; step i uses si_pat[i mod 4].
REQ-009 pause  input  1  freezes the run phase while high.
REQ-010 q_in  input  4  Q output of the controlled 4-bit shift register.
REQ-011 M  output  2  register mode: 00 hold, 01 load, 10 rotate left, 11 shift right.
REQ-012 D  output  4  parallel load data to the register.
REQ-013 SI  output  1  serial input to the register.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  registered one-cycle completion pulse.
REQ-016 result  output  4  register contents captured at completion.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, DONE; M, D and SI are Moore outputs decoded from state and the latched command.
REQ-018 IDLE: M=00, D=0, SI=0; if start=1 at an edge, latch op/init/cnt/si_pat, clear step counter, go to LOAD.
REQ-019 Inputs op/init/cnt/si_pat changing while busy=1 have no effect; start while busy=1 is ignored, not queued.
REQ-020 LOAD: M=01, D=latched init, SI=0; lasts exactly one cycle (pause ignored); next state RUN if cnt!=0, else DONE.
REQ-021 RUN, pause=0: M=10 (op=0) or 11 (op=1), SI=si_pat[step[1:0]] when op=1 else 0, D=0; step increments each edge.
REQ-022 RUN, pause=1: M=00, SI=0; step and state unchanged; pause may be held any number of cycles.
REQ-023 RUN exits to DONE at the edge where step reaches cnt-1 with pause=0; exactly cnt non-paused RUN cycles are issued.
REQ-024 DONE: M=00; lasts one cycle; at its closing edge result<=q_in, done<=1, state->IDLE.
REQ-025 done is high for exactly the one cycle after DONE, otherwise 0; result holds until the next completion.
REQ-026 Latency: start sampled at edge k with no pause -> done high in the cycle after edge k+cnt+2; each paused cycle adds one.
REQ-027 A start sampled in the same IDLE cycle that done=1 is accepted normally (back-to-back commands).
REQ-028 Step counter is CNT_W bits; maximum cnt issues 2^CNT_W-1 steps with no wrap-around error; si_pat index wraps mod 4.

Reset
REQ-029 rst=1 at an edge forces IDLE, step=0, done=0, result=0000, busy=0, M=00, D=0, SI=0, regardless of state.
REQ-030 rst mid-command aborts it: no done pulse and result unchanged from 0000; the next start after rst deasserts behaves normally.
REQ-031 rst has priority over start and pause in the same cycle.

Verification
REQ-032 op=1, init=1101, cnt=2, si_pat=0010 -> M sequence 01,11,11,00; SI 0 then 1; result=1011; done 4 cycles after start edge.
REQ-033 op=0, init=1011, cnt=2 -> register 0111 then 1110; result=1110; M never 11.
REQ-034 cnt=0, init=1001 -> LOAD then DONE only; result=1001; done in the cycle after edge k+2.
REQ-035 op=1, init=1101, cnt=2, si_pat=0010, pause high for 3 cycles after first RUN step -> M=00 during pause; result=1011; done 3 cycles later than REQ-032.
REQ-036 rst asserted during RUN of a cnt=5 command -> busy=0, M=00 the next cycle, no done; start asserted with init=0110, cnt=0 while busy (ignored); a later start completes with correct result.
REQ-037 Back-to-back: start held high continuously with cnt=1 -> each command completes, done pulses every 4 cycles, each new command starts in the done cycle.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencer for an external 4-bit universal shift register. A command
//   loads a value into the register, then issues a programmable number of
//   rotate-left or shift-right steps. It then captures the register contents
//   and reports completion with a single-cycle pulse.
//
// Ports
//   clk     : system clock, all state changes on its rising edge
//   rst     : synchronous active-high reset
//   start   : command request, only accepted while idle
//   op      : 0 = rotate left, 1 = shift right with serial-in
//   init    : value loaded into the register when the command starts
//   cnt     : number of shift/rotate steps (0 allowed)
//   si_pat  : serial-in pattern, step i uses si_pat[i mod 4]
//   pause   : freezes the stepping phase while high
//   q_in    : current Q of the controlled register
//   M       : register mode (00 hold, 01 load, 10 rotate left, 11 shift right)
//   D       : parallel load data to the register
//   SI      : serial input to the register
//   busy    : high while a command is in progress
//   done    : one-cycle completion pulse
//   result  : register contents captured at completion
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [3:0]       init,
  input  logic [CNT_W-1:0] cnt,
  input  logic [3:0]       si_pat,
  input  logic             pause,
  input  logic [3:0]       q_in,
  output logic [1:0]       M,
  output logic [3:0]       D,
  output logic             SI,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_ROTL  = 2'b10;
  localparam logic [1:0] MODE_SHR   = 2'b11;

  state_t           r_state;
  state_t           w_next;

  logic             r_op;
  logic [3:0]       r_init;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_siPat;
  logic [CNT_W-1:0] r_step;
  // Separate 2-bit pattern index so the mod-4 wrap works for any CNT_W,
  // including widths narrower than two bits.
  logic [1:0]       r_siIdx;
  logic             r_done;
  logic [3:0]       r_result;

  logic             w_lastStep;

  // RUN is only entered with a non-zero count, so cnt-1 never underflows
  // while it is being used.
  assign w_lastStep = (r_step == (r_cnt - CNT_W'(1)));

  // Next-state and Moore output decode. Pause only affects the RUN phase;
  // LOAD and DONE always last exactly one cycle.
  always_comb begin
    w_next = r_state;
    M      = MODE_HOLD;
    D      = 4'b0000;
    SI     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        M      = MODE_LOAD;
        D      = r_init;
        w_next = (r_cnt != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (!pause) begin
          M  = r_op ? MODE_SHR : MODE_ROTL;
          SI = r_op ? r_siPat[r_siIdx] : 1'b0;
          if (w_lastStep) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, command latch, step counting and completion capture.
  // The command is latched only on acceptance, so inputs changing while
  // busy have no effect. done is cleared every cycle except the one that
  // follows DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 1'b0;
      r_init   <= 4'b0000;
      r_cnt    <= '0;
      r_siPat  <= 4'b0000;
      r_step   <= '0;
      r_siIdx  <= 2'b00;
      r_done   <= 1'b0;
      r_result <= 4'b0000;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_init  <= init;
            r_cnt   <= cnt;
            r_siPat <= si_pat;
            r_step  <= '0;
            r_siIdx <= 2'b00;
          end
        end
        S_RUN: begin
          if (!pause) begin
            r_step  <= r_step + CNT_W'(1);
            r_siIdx <= r_siIdx + 2'd1;
          end
        end
        S_DONE: begin
          r_result <= q_in;
          r_done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Drives shift_seq_ctrl against a behavioural model of the 4-bit register
//   it controls. Every accepted command pushes its expected result and
//   completion cycle onto a scoreboard. A negedge monitor pops and compares
//   the scoreboard whenever done pulses.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             op;
  logic [3:0]       init;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       si_pat;
  logic             pause;
  logic [3:0]       q_in;
  logic [1:0]       M;
  logic [3:0]       D;
  logic             SI;
  logic             busy;
  logic             done;
  logic [3:0]       result;

  shift_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .init   (init),
    .cnt    (cnt),
    .si_pat (si_pat),
    .pause  (pause),
    .q_in   (q_in),
    .M      (M),
    .D      (D),
    .SI     (SI),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cycleCnt == n.
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  // Behavioural model of the controlled register: serial-in enters at the
  // MSB on a right shift.
  logic [3:0] regQ = 4'b0000;
  always @(posedge clk) begin
    case (M)
      2'b01:   regQ <= D;
      2'b10:   regQ <= {regQ[2:0], regQ[3]};
      2'b11:   regQ <= {SI, regQ[3:1]};
      default: regQ <= regQ;
    endcase
  end
  assign q_in = regQ;

  typedef struct {
    logic [3:0] res;
    int         cyc;
  } exp_t;

  exp_t sbQ[$];

  int vecCount  = 0;
  int missCount = 0;

  logic [1:0] mTrace  [64];
  logic       siTrace [64];
  logic [3:0] dTrace  [64];
  logic [3:0] qTrace  [64];
  int         doneAt;
  logic       prevDone = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecCount++;
    if (obs !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cycleCnt);
    end
  endtask

  // Independent reference for the final register contents of a command.
  function automatic logic [3:0] modelResult(input logic o, input logic [3:0] iv,
                                             input int n, input logic [3:0] pat);
    logic [3:0] q;
    q = iv;
    for (int i = 0; i < n; i++) begin
      q = o ? {pat[2'(i)], q[3:1]} : {q[2:0], q[3]};
    end
    return q;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done) begin
      checkOutput("busy in done cycle", 32'(busy), 0);
      checkOutput("done pulse width", 32'(prevDone), 0);
      if (sbQ.size() == 0) begin
        checkOutput("spurious done", 32'(done), 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("done cycle", cycleCnt, e.cyc);
      end
    end
    prevDone = done;
  end

  // Issues one command and follows it until done, scrambling the command
  // inputs while busy. pmask[j] drives pause in cycle j after the accepting
  // edge; extra is the latency that pause is expected to add.
  task automatic applyStimulus(input logic o, input logic [3:0] iv, input int n,
                               input logic [3:0] pat, input logic [15:0] pmask,
                               input int extra);
    exp_t e;
    bit   seen;
    start  = 1'b1;
    op     = o;
    init   = iv;
    cnt    = n[CNT_W-1:0];
    si_pat = pat;
    pause  = 1'b0;
    e.res  = modelResult(o, iv, n, pat);
    e.cyc  = cycleCnt + 1 + n + 2 + extra;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    seen   = 1'b0;
    doneAt = -1;
    for (int j = 0; j < 64 && !seen; j++) begin
      pause  = (j < 16) ? pmask[j] : 1'b0;
      op     = 1'($urandom);
      init   = 4'($urandom);
      cnt    = CNT_W'($urandom);
      si_pat = 4'($urandom);
      @(negedge clk);
      mTrace[j]  = M;
      siTrace[j] = SI;
      dTrace[j]  = D;
      qTrace[j]  = q_in;
      if (done) begin
        seen   = 1'b1;
        doneAt = j;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    pause = 1'b0;
    checkOutput("done timeout", 32'(seen), 1);
  endtask

  initial begin
    int cnt11;
    int k;

    rst    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    init   = 4'b0000;
    cnt    = '0;
    si_pat = 4'b0000;
    pause  = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset M", 32'(M), 0);
    checkOutput("reset D", 32'(D), 0);
    checkOutput("reset SI", 32'(SI), 0);
    checkOutput("reset result", 32'(result), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Shift right with serial-in
    applyStimulus(1'b1, 4'b1101, 2, 4'b0010, 16'h0000, 0);
    checkOutput("shr M0", 32'(mTrace[0]), 32'b01);
    checkOutput("shr D0", 32'(dTrace[0]), 32'b1101);
    checkOutput("shr M1", 32'(mTrace[1]), 32'b11);
    checkOutput("shr SI1", 32'(siTrace[1]), 0);
    checkOutput("shr M2", 32'(mTrace[2]), 32'b11);
    checkOutput("shr SI2", 32'(siTrace[2]), 1);
    checkOutput("shr M3", 32'(mTrace[3]), 32'b00);
    checkOutput("shr q2", 32'(qTrace[2]), 32'b0110);
    checkOutput("shr doneAt", doneAt, 4);

    // Rotate left
    applyStimulus(1'b0, 4'b1011, 2, 4'b1111, 16'h0000, 0);
    checkOutput("rotl q2", 32'(qTrace[2]), 32'b0111);
    checkOutput("rotl q3", 32'(qTrace[3]), 32'b1110);
    cnt11 = 0;
    for (int j = 0; j <= doneAt && j < 64; j++) begin
      if (mTrace[j] == 2'b11) cnt11++;
      if (siTrace[j] != 1'b0) cnt11++;
    end
    checkOutput("rotl never shr", cnt11, 0);

    // Zero-step command
    applyStimulus(1'b1, 4'b1001, 0, 4'b1111, 16'h0000, 0);
    checkOutput("cnt0 M0", 32'(mTrace[0]), 32'b01);
    checkOutput("cnt0 M1", 32'(mTrace[1]), 32'b00);
    checkOutput("cnt0 doneAt", doneAt, 2);

    // Pause for three cycles after the first step
    applyStimulus(1'b1, 4'b1101, 2, 4'b0010, 16'h001C, 3);
    for (int j = 2; j <= 4; j++) begin
      checkOutput("pause M", 32'(mTrace[j]), 0);
      checkOutput("pause SI", 32'(siTrace[j]), 0);
    end
    checkOutput("pause resume M", 32'(mTrace[5]), 32'b11);
    checkOutput("pause resume SI", 32'(siTrace[5]), 1);
    checkOutput("pause doneAt", doneAt, 7);

    // Pause during LOAD is ignored
    applyStimulus(1'b0, 4'b0011, 3, 4'b0000, 16'h0001, 0);
    checkOutput("load ignores pause", 32'(mTrace[0]), 32'b01);

    // Maximum step count, serial-in index wraps several times
    applyStimulus(1'b1, 4'b0000, 15, 4'b1010, 16'h0000, 0);
    applyStimulus(1'b0, 4'b1000, 15, 4'b0000, 16'h0000, 0);

    // Random commands, issued back to back
    for (int r = 0; r < 12; r++) begin
      applyStimulus(1'($urandom), 4'($urandom), int'($urandom_range(0, 15)),
                    4'($urandom), 16'h0000, 0);
    end

    // Reset abort, with an ignored start while busy
    start  = 1'b1;
    op     = 1'b0;
    init   = 4'b1010;
    cnt    = 4'd5;
    si_pat = 4'b0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    init  = 4'b0110;
    cnt   = 4'd0;
    @(negedge clk);
    checkOutput("abort busy run", 32'(busy), 1);
    checkOutput("abort M run", 32'(M), 32'b10);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("ignored start M", 32'(M), 32'b10);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    pause = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort M", 32'(M), 0);
    checkOutput("abort D", 32'(D), 0);
    checkOutput("abort SI", 32'(SI), 0);
    checkOutput("abort done", 32'(done), 0);
    checkOutput("abort result", 32'(result), 0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("idle after abort", 32'(busy), 0);
    end
    applyStimulus(1'b1, 4'b0110, 3, 4'b0101, 16'h0000, 0);

    // start held high: three one-step commands, one every four cycles
    start  = 1'b1;
    op     = 1'b0;
    init   = 4'b1001;
    cnt    = 4'd1;
    si_pat = 4'b0000;
    k = cycleCnt + 1;
    for (int c = 0; c < 3; c++) begin
      exp_t e;
      e.res = 4'b0011;
      e.cyc = k + 3 + 4 * c;
      sbQ.push_back(e);
    end
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < 30 && sbQ.size() != 0; t++) begin
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    checkOutput("final idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
